// File: rtl/perf_pkg.sv
// Shared constants for the performance event monitor: FSM state encoding and
// the width of the snapshot readout select.
package perf_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Select width that addresses the cycle counter plus num_evt event counters.
  function automatic int unsigned sel_w(input int unsigned num_evt);
    return (num_evt + 1 <= 2) ? 1 : $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky flag for increments attempted at all-ones.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      if (&count_q) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Run-cycle and hazard-event monitor with a programmable cycle limit and an
// atomic snapshot of all counters for zero-latency readout.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT     = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 30
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [NUM_EVT-1:0]           evt_i,
  input  logic                         snap_req_i,
  input  logic [sel_w(NUM_EVT)-1:0]    rd_sel_i,
  output logic [STATE_W-1:0]           state_o,
  output logic [CNT_W-1:0]             cycle_o,
  output logic                         done_o,
  output logic                         snap_valid_o,
  output logic [CNT_W-1:0]             snap_data_o,
  output logic [NUM_EVT:0]             ovf_o
);

  localparam int unsigned NUM_CNT = NUM_EVT + 1;
  localparam int unsigned SEL_W   = sel_w(NUM_EVT);

  // A limit the cycle counter can never reach (beyond all-ones) acts as unlimited.
  localparam bit LIM_EN = (CYCLE_LIMIT != 0) &&
                          ((CNT_W >= 32) || (64'(CYCLE_LIMIT) < (64'd1 << CNT_W)));
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               done_q, done_d;
  logic [NUM_CNT-1:0] cnt_en;
  logic [CNT_W-1:0]   cnt_w     [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q  [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d  [NUM_CNT];
  logic               snap_valid_q, snap_valid_d;
  logic               limit_hit;

  assign limit_hit = LIM_EN && (cnt_w[0] == LIMIT_M1);

  // Next-state and counter enables; clear wins over everything but reset.
  always_comb begin
    state_d = state_q;
    cnt_en  = '0;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start_i) begin
            cnt_en = {evt_i, 1'b1};
            if (limit_hit) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Slot 0 counts run cycles, slot k counts event channel k-1.
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (cnt_en[g]),
      .clr_i   (clear_i),
      .count_o (cnt_w[g]),
      .ovf_o   (ovf_o[g])
    );
  end

  // Shadow capture takes pre-edge counter values; a request alongside clear is dropped.
  always_comb begin
    shadow_d     = shadow_q;
    snap_valid_d = snap_valid_q;
    if (clear_i) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow_d[i] = '0;
      snap_valid_d = 1'b0;
    end else if (snap_req_i) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow_d[i] = cnt_w[i];
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow_q[i] <= shadow_d[i];
      snap_valid_q <= snap_valid_d;
    end
  end

  always_comb begin
    snap_data_o = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) snap_data_o = shadow_q[i];
    end
  end

  assign state_o      = state_q;
  assign done_o       = done_q;
  assign cycle_o      = cnt_w[0];
  assign snap_valid_o = snap_valid_q;

endmodule
